// File: rtl/mult_pkg.sv
// Shared defaults and FSM encoding for the time-shared multiplier controller.
package mult_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDW   = $clog2(NREQ);
    localparam int unsigned CTRW  = $clog2(2 * WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_mult_core.sv
// Restartable shift-add two's-complement multiplier: one partial product per cycle,
// 2*WIDTH iterations per start pulse; p holds the last finished product.
module seq_mult_core
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = mult_pkg::WIDTH,
    parameter int unsigned CTRW  = mult_pkg::CTRW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   p,
    output logic                 done,
    output logic                 last_c
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned SW = $clog2(PW);

    logic [PW-1:0]   mcand;
    logic [PW-1:0]   mplier;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   acc_nxt;
    logic [CTRW-1:0] ctr;
    logic [SW-1:0]   sh;
    logic            running;

    // Operands are sign-extended to PW bits, so the truncated sum is the exact product.
    always_comb begin
        sh      = ctr[SW-1:0];
        acc_nxt = acc + ((mplier & {PW{mcand[sh]}}) << sh);
        last_c  = running && (ctr == CTRW'(PW - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            ctr     <= '0;
            running <= 1'b0;
            p       <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                mcand   <= {{WIDTH{a[WIDTH-1]}}, a};
                mplier  <= {{WIDTH{b[WIDTH-1]}}, b};
                acc     <= '0;
                ctr     <= '0;
                running <= 1'b1;
            end else if (running) begin
                acc <= acc_nxt;
                ctr <= ctr + CTRW'(1);
                if (last_c) begin
                    running <= 1'b0;
                    p       <= acc_nxt;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Round-robin front end sharing one sequential multiplier among NREQ requesters;
// products come back tagged with the owning requester id.
module mult_share_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = mult_pkg::WIDTH,
    parameter int unsigned NREQ  = mult_pkg::NREQ,
    parameter int unsigned IDW   = $clog2(NREQ),
    parameter int unsigned CTRW  = $clog2(2 * WIDTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   a_in,
    input  logic [NREQ*WIDTH-1:0]   b_in,
    output logic [NREQ-1:0]         gnt,
    output logic [2*WIDTH-1:0]      p_out,
    output logic                    p_valid,
    output logic [IDW-1:0]          p_id,
    output logic                    busy
);

    state_e           state;
    state_e           state_nxt;
    logic [IDW-1:0]   last;
    logic [IDW-1:0]   id_q;
    logic [IDW-1:0]   win;
    logic             req_any;
    logic             start;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic             core_last;

    // Round-robin pick: first requester after the last one served, wrapping at NREQ.
    always_comb begin
        int idx;
        idx     = 0;
        win     = '0;
        req_any = 1'b0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            idx = (int'(last) + k) % int'(NREQ);
            if (!req_any && req[idx]) begin
                win     = IDW'(idx);
                req_any = 1'b1;
            end
        end
        a_sel = a_in[int'(win) * int'(WIDTH) +: WIDTH];
        b_sel = b_in[int'(win) * int'(WIDTH) +: WIDTH];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt       = '0;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    gnt       = NREQ'(1) << win;
                    start     = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (core_last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pointer and id bookkeeping; p_id switches together with p_out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last <= IDW'(NREQ - 1);
            id_q <= '0;
            p_id <= '0;
        end else begin
            if (start) begin
                last <= win;
                id_q <= win;
            end
            if ((state == RUN) && core_last) begin
                p_id <= id_q;
            end
        end
    end

    seq_mult_core #(
        .WIDTH (WIDTH),
        .CTRW  (CTRW)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a_sel),
        .b      (b_sel),
        .p      (p_out),
        .done   (p_valid),
        .last_c (core_last)
    );

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl with hand-computed products and grant orders.
module tb_mult_share_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [3:0]  gnt;
    logic [15:0] p_out;
    logic        p_valid;
    logic [1:0]  p_id;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int t_gnt = 0;

    mult_share_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .a_in    (a_in),
        .b_in    (b_in),
        .gnt     (gnt),
        .p_out   (p_out),
        .p_valid (p_valid),
        .p_id    (p_id),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        a_in[i*8 +: 8] = 8'(a);
        b_in[i*8 +: 8] = 8'(b);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Wait for a grant, check it, apply post-grant inputs, then check the tagged result.
    task automatic serve(input logic [3:0] exp_gnt, input logic [15:0] exp_p,
                         input logic [1:0] exp_id, input logic [3:0] req_after,
                         input logic [31:0] a_after, input logic [31:0] b_after);
        int  lat;
        bit  got;
        #1;
        got = 1'b0;
        for (int w = 0; w < 40; w++) begin
            if (gnt != 4'b0) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        check("gnt_seen", 32'(got), 32'd1);
        if (!got) return;
        t_gnt = cyc;
        check("gnt", 32'(gnt), 32'(exp_gnt));
        @(posedge clk);
        #1;
        req  = req_after;
        a_in = a_after;
        b_in = b_after;
        got  = 1'b0;
        for (lat = 1; lat <= 40; lat++) begin
            @(negedge clk);
            if (lat == 1) begin
                check("gnt_pulse", 32'(gnt), 32'd0);
                check("busy_run", 32'(busy), 32'd1);
            end
            if (p_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("pv_seen", 32'(got), 32'd1);
        if (!got) return;
        check("latency", 32'(lat), 32'd17);
        check("p_out", 32'(p_out), 32'(exp_p));
        check("p_id", 32'(p_id), 32'(exp_id));
        check("busy_done", 32'(busy), 32'd1);
        @(negedge clk);
        check("pv_pulse", 32'(p_valid), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic single(input int i, input int a, input int b, input logic [15:0] exp_p);
        set_ops(i, a, b);
        req = 4'(1) << i;
        serve(4'(1) << i, exp_p, 2'(i), 4'b0, a_in, b_in);
    endtask

    logic [15:0] cont_p [4] = '{16'hFFF4, 16'hFFC1, 16'hD8F0, 16'h0BB8};

    initial begin
        int prev;
        reset = 1'b1;
        req   = 4'b0;
        a_in  = '0;
        b_in  = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_p_out", 32'(p_out), 32'd0);
        check("rst_p_valid", 32'(p_valid), 32'd0);
        check("rst_p_id", 32'(p_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        single(0, 3, 5, 16'h000F);
        single(0, -128, -128, 16'h4000);
        single(0, -128, 127, 16'hC080);
        single(0, -1, -1, 16'h0001);
        single(0, 0, -77, 16'h0000);

        // Requester 3 served last, then 1 and 3 request together and stay up.
        single(3, 2, -3, 16'hFFFA);
        set_ops(1, 5, 6);
        set_ops(3, -9, 11);
        req = 4'b1010;
        serve(4'b0010, 16'h001E, 2'd1, 4'b1010, a_in, b_in);
        serve(4'b1000, 16'hFF9D, 2'd3, 4'b0000, a_in, b_in);

        // Operands and req change right after the grant; the product must not move.
        set_ops(2, 12, -11);
        req = 4'b0100;
        serve(4'b0100, 16'hFF7C, 2'd2, 4'b0000, 32'h6363_6363, 32'h6363_6363);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_extra_gnt", 32'(gnt), 32'd0);
        end

        // Asynchronous reset in the middle of a product.
        set_ops(0, 7, -8);
        req = 4'b0001;
        #1;
        check("abort_gnt", 32'(gnt), 32'd1);
        @(posedge clk);
        #1;
        req = 4'b0;
        repeat (8) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_p_valid", 32'(p_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        single(0, -13, 11, 16'hFF71);

        // All four requesting continuously from a fresh pointer.
        reset_dut();
        set_ops(0, 3, -4);
        set_ops(1, -7, 9);
        set_ops(2, 100, -100);
        set_ops(3, -50, -60);
        req  = 4'hF;
        prev = 0;
        for (int g = 0; g < 5; g++) begin
            serve(4'(1) << (g % 4), cont_p[g % 4], 2'(g % 4),
                  (g == 4) ? 4'h0 : 4'hF, a_in, b_in);
            if (g > 0) check("spacing", 32'(t_gnt - prev), 32'd18);
            prev = t_gnt;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
